// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Stall (hold) and flush (clear) control for the F/D/E/M/W pipeline
//   registers, plus timing of the fixed-latency multicycle (MDU) op in
//   Execute.
//
//   A pipeline register only honours its clear while it is enabled. A flush
//   that lands on a stalled stage is therefore remembered in a pending bit.
//   That bit keeps FlushX high until the stage advances, so exactly one
//   enabled+clear edge takes place.
//
// Parameters
//   MDU_LATENCY  cycles an MDU op occupies E before its result is ready (>=1)
//
// Ports
//   clk                  clock
//   reset                synchronous, active-high reset
//   IFUStallF            instruction fetch miss in progress
//   LSUStallM            data access miss in progress
//   LoadStallD           load-use hazard between D and a load in E
//   MDUStartE            multicycle op present in E (first cycle seen)
//   BPWrongE             branch misprediction resolved in E
//   TrapM                trap/exception taken in M
//   StallF..StallW       hold the stage register
//   FlushD..FlushW       clear the stage register
//   MDUBusyE             MDU op in progress
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int MDU_LATENCY = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic IFUStallF,
  input  logic LSUStallM,
  input  logic LoadStallD,
  input  logic MDUStartE,
  input  logic BPWrongE,
  input  logic TrapM,
  output logic StallF,
  output logic StallD,
  output logic StallE,
  output logic StallM,
  output logic StallW,
  output logic FlushD,
  output logic FlushE,
  output logic FlushM,
  output logic FlushW,
  output logic MDUBusyE
);

  localparam int CW = $clog2(MDU_LATENCY + 1);
  localparam logic [CW-1:0] MDU_LOAD = CW'(MDU_LATENCY - 1);

  logic [CW-1:0] mdu_cnt;
  logic          abort;
  logic          busy;
  logic          stall_f, stall_d, stall_e, stall_m, stall_w;
  logic          flush_raw_d, flush_raw_e, flush_raw_m, flush_raw_w;
  logic          flush_d, flush_e, flush_m, flush_w;
  logic          pend_d, pend_e, pend_m, pend_w;

  // Stall chain and flush causes. Nothing here depends on Flush* except
  // through the listed raw causes, so the chain is loop-free.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' so each later line sees the
    // value computed above it within the same evaluation.
    abort = TrapM | BPWrongE;
    // An abort drops busy in the same cycle so E can take the flush.
    busy  = (mdu_cnt != '0) && !abort;

    stall_w     = IFUStallF | LSUStallM;
    stall_m     = stall_w;
    stall_e     = stall_m | (busy & ~TrapM);
    flush_raw_d = BPWrongE | TrapM;
    // A flush of D kills the dependent instruction, so no load-use stall.
    stall_d     = stall_e | (LoadStallD & ~flush_raw_d);
    stall_f     = stall_d;

    // A stage that holds while the next one advances inserts a bubble.
    flush_raw_e = BPWrongE | TrapM | (stall_d & ~stall_e);
    flush_raw_m = TrapM | (stall_e & ~stall_m);
    flush_raw_w = TrapM | (stall_m & ~stall_w);

    flush_d = flush_raw_d | pend_d;
    flush_e = flush_raw_e | pend_e;
    flush_m = flush_raw_m | pend_m;
    flush_w = flush_raw_w | pend_w;
  end

  // Output stage: reset clears every register and stalls nothing.
  always_comb begin
    // NOTE: every output gets a value on every path through this block;
    // a missing else-branch would infer a latch.
    StallF   = 1'b0;
    StallD   = 1'b0;
    StallE   = 1'b0;
    StallM   = 1'b0;
    StallW   = 1'b0;
    FlushD   = 1'b1;
    FlushE   = 1'b1;
    FlushM   = 1'b1;
    FlushW   = 1'b1;
    MDUBusyE = 1'b0;
    if (!reset) begin
      StallF   = stall_f;
      StallD   = stall_d;
      StallE   = stall_e;
      StallM   = stall_m;
      StallW   = stall_w;
      FlushD   = flush_d;
      FlushE   = flush_e;
      FlushM   = flush_m;
      FlushW   = flush_w;
      MDUBusyE = busy;
    end
  end

  // Pending flushes and MDU occupancy counter.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking '<=' so every register
    // samples values from before this edge, independent of statement order.
    if (reset) begin
      pend_d  <= 1'b0;
      pend_e  <= 1'b0;
      pend_m  <= 1'b0;
      pend_w  <= 1'b0;
      mdu_cnt <= '0;
    end else begin
      // Held while the stage stays stalled, dropped once it advances.
      pend_d <= stall_d & (pend_d | flush_raw_d);
      pend_e <= stall_e & (pend_e | flush_raw_e);
      pend_m <= stall_m & (pend_m | flush_raw_m);
      pend_w <= stall_w & (pend_w | flush_raw_w);

      // Counts down regardless of downstream stalls; a start seen while
      // already counting is the same op and is ignored.
      if (abort)
        mdu_cnt <= '0;
      else if (MDUStartE && (mdu_cnt == '0) && !flush_e)
        mdu_cnt <= MDU_LOAD;
      else if (mdu_cnt != '0)
        mdu_cnt <= mdu_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//   Directed vectors for pipe_hazard_ctrl. Each scenario task applies one
//   input pattern per cycle and compares the packed outputs against a
//   hand-computed table.
//   Input vector layout : {reset, IFUStallF, LSUStallM, LoadStallD,
//                          MDUStartE, BPWrongE, TrapM}
//   Output vector layout: {StallF, StallD, StallE, StallM, StallW,
//                          FlushD, FlushE, FlushM, FlushW, MDUBusyE}
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic [6:0] in_vec = 7'b1000000;

  logic reset, IFUStallF, LSUStallM, LoadStallD, MDUStartE, BPWrongE, TrapM;
  logic StallF, StallD, StallE, StallM, StallW;
  logic FlushD, FlushE, FlushM, FlushW, MDUBusyE;
  logic s1f, s1d, s1e, s1m, s1w, f1d, f1e, f1m, f1w, busy1;

  int vectors = 0;
  int miscompares = 0;

  assign {reset, IFUStallF, LSUStallM, LoadStallD, MDUStartE, BPWrongE, TrapM} = in_vec;

  wire [9:0] obs = {StallF, StallD, StallE, StallM, StallW,
                    FlushD, FlushE, FlushM, FlushW, MDUBusyE};

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MDU_LATENCY(4)) dut (
    .clk(clk), .reset(reset), .IFUStallF(IFUStallF), .LSUStallM(LSUStallM),
    .LoadStallD(LoadStallD), .MDUStartE(MDUStartE), .BPWrongE(BPWrongE),
    .TrapM(TrapM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .StallW(StallW), .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
    .FlushW(FlushW), .MDUBusyE(MDUBusyE)
  );

  // Minimum-latency instance: a start never produces a busy cycle.
  pipe_hazard_ctrl #(.MDU_LATENCY(1)) dut_lat1 (
    .clk(clk), .reset(reset), .IFUStallF(IFUStallF), .LSUStallM(LSUStallM),
    .LoadStallD(LoadStallD), .MDUStartE(MDUStartE), .BPWrongE(BPWrongE),
    .TrapM(TrapM),
    .StallF(s1f), .StallD(s1d), .StallE(s1e), .StallM(s1m), .StallW(s1w),
    .FlushD(f1d), .FlushE(f1e), .FlushM(f1m), .FlushW(f1w), .MDUBusyE(busy1)
  );

  // Apply new inputs shortly after the rising edge, sample before the next.
  task automatic apply(input logic [6:0] v);
    @(posedge clk);
    #1 in_vec = v;
    #2;
  endtask

  task automatic test_reset();
    logic [6:0] stim [4] = '{7'b1000000, 7'b1000000, 7'b0000000, 7'b0000000};
    logic [9:0] expv [4] = '{10'b00000_1111_0, 10'b00000_1111_0,
                             10'b00000_0000_0, 10'b00000_0000_0};
    for (int i = 0; i < 4; i++) begin
      apply(stim[i]);
      vectors++;
      if (obs !== expv[i]) begin
        miscompares++;
        $display("FAIL reset[%0d]: got %b want %b", i, obs, expv[i]);
      end
    end
  endtask

  task automatic test_load_use();
    logic [6:0] stim [2] = '{7'b0001000, 7'b0000000};
    // Load-use: F/D hold, E receives a bubble.
    logic [9:0] expv [2] = '{10'b11000_0100_0, 10'b00000_0000_0};
    for (int i = 0; i < 2; i++) begin
      apply(stim[i]);
      vectors++;
      if (obs !== expv[i]) begin
        miscompares++;
        $display("FAIL load_use[%0d]: got %b want %b", i, obs, expv[i]);
      end
    end
  endtask

  task automatic test_mdu();
    // Start in cycle 0, start held again in cycle 1 (same op, ignored).
    logic [6:0] stim [5] = '{7'b0000100, 7'b0000100, 7'b0000000,
                             7'b0000000, 7'b0000000};
    logic [9:0] expv [5] = '{10'b00000_0000_0, 10'b11100_0010_1,
                             10'b11100_0010_1, 10'b11100_0010_1,
                             10'b00000_0000_0};
    for (int i = 0; i < 5; i++) begin
      apply(stim[i]);
      vectors++;
      if (obs !== expv[i]) begin
        miscompares++;
        $display("FAIL mdu[%0d]: got %b want %b", i, obs, expv[i]);
      end
      vectors++;
      if ({busy1, s1e} !== 2'b00) begin
        miscompares++;
        $display("FAIL mdu_lat1[%0d]: got busy/stallE %b want 00", i, {busy1, s1e});
      end
    end
  endtask

  task automatic test_trap_pending();
    // Trap in cycle 1 of a 5-cycle data miss. The clears stay up while
    // every stage holds, and the first unstalled cycle carries them into
    // the registers; the cycle after that is clean.
    logic [6:0] stim [7] = '{7'b0010001, 7'b0010000, 7'b0010000, 7'b0010000,
                             7'b0010000, 7'b0000000, 7'b0000000};
    logic [9:0] expv [7] = '{10'b11111_1111_0, 10'b11111_1111_0,
                             10'b11111_1111_0, 10'b11111_1111_0,
                             10'b11111_1111_0, 10'b00000_1111_0,
                             10'b00000_0000_0};
    for (int i = 0; i < 7; i++) begin
      apply(stim[i]);
      vectors++;
      if (obs !== expv[i]) begin
        miscompares++;
        $display("FAIL trap_pending[%0d]: got %b want %b", i, obs, expv[i]);
      end
    end
  endtask

  task automatic test_mdu_abort();
    // Mispredict in busy cycle 2 kills the op immediately.
    logic [6:0] stim [4] = '{7'b0000100, 7'b0000000, 7'b0000010, 7'b0000000};
    logic [9:0] expv [4] = '{10'b00000_0000_0, 10'b11100_0010_1,
                             10'b00000_1100_0, 10'b00000_0000_0};
    for (int i = 0; i < 4; i++) begin
      apply(stim[i]);
      vectors++;
      if (obs !== expv[i]) begin
        miscompares++;
        $display("FAIL mdu_abort[%0d]: got %b want %b", i, obs, expv[i]);
      end
    end
  endtask

  task automatic test_simultaneous();
    // Trap + mispredict + load-use: all stages clear, no stall, nothing held.
    logic [6:0] stim [2] = '{7'b0001011, 7'b0000000};
    logic [9:0] expv [2] = '{10'b00000_1111_0, 10'b00000_0000_0};
    for (int i = 0; i < 2; i++) begin
      apply(stim[i]);
      vectors++;
      if (obs !== expv[i]) begin
        miscompares++;
        $display("FAIL simultaneous[%0d]: got %b want %b", i, obs, expv[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    // MDU op with a fetch miss during its last busy cycle and beyond:
    // counter keeps running, E stays held by the downstream stall, then a
    // load-use immediately follows release.
    logic [6:0] stim [7] = '{7'b0000100, 7'b0000000, 7'b0000000, 7'b0100000,
                             7'b0100000, 7'b0001000, 7'b0000000};
    logic [9:0] expv [7] = '{10'b00000_0000_0, 10'b11100_0010_1,
                             10'b11100_0010_1, 10'b11111_0000_1,
                             10'b11111_0000_0, 10'b11000_0100_0,
                             10'b00000_0000_0};
    for (int i = 0; i < 7; i++) begin
      apply(stim[i]);
      vectors++;
      if (obs !== expv[i]) begin
        miscompares++;
        $display("FAIL back_to_back[%0d]: got %b want %b", i, obs, expv[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    // Reset during an MDU op and a held flush discards both.
    logic [6:0] stim [5] = '{7'b0000100, 7'b0010001, 7'b1010000,
                             7'b0000000, 7'b0000000};
    logic [9:0] expv [5] = '{10'b00000_0000_0, 10'b11111_1111_0,
                             10'b00000_1111_0, 10'b00000_0000_0,
                             10'b00000_0000_0};
    for (int i = 0; i < 5; i++) begin
      apply(stim[i]);
      vectors++;
      if (obs !== expv[i]) begin
        miscompares++;
        $display("FAIL reset_mid[%0d]: got %b want %b", i, obs, expv[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_mdu();
    test_trap_pending();
    test_mdu_abort();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
